// File: rtl/aes_uart_pkg.sv
// Shared types and widths for the AES block to UART byte serializer.
package aes_uart_pkg;

  localparam int AES_BLOCK_BITS = 128;
  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_GAP,
    ST_FIN
  } state_t;

endpackage

// File: rtl/aes_block_uart_serializer.sv
// Feeds a latched AES ciphertext block to UART_Tx one byte per frame.
// Optional trailing XOR checksum byte when AES_TX_CHECKSUM_EN is defined.
module aes_block_uart_serializer
  import aes_uart_pkg::*;
#(
  parameter int NUM_BYTES  = AES_BLOCK_BITS / UART_DATA_BITS,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int GAP_CYCLES = 0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                en,
  input  logic                                blk_valid,
  input  logic [UART_DATA_BITS*NUM_BYTES-1:0] blk_data,
  output logic                                blk_ready,
  output logic                                tx_start,
  output logic [UART_DATA_BITS-1:0]           tx_data,
  input  logic                                tx_done,
  output logic                                busy,
  output logic                                done
);

  localparam int BLK_W = UART_DATA_BITS * NUM_BYTES;
  localparam int CNT_W = $clog2(NUM_BYTES + 1);
`ifdef AES_TX_CHECKSUM_EN
  localparam int LAST_IDX = NUM_BYTES;
`else
  localparam int LAST_IDX = NUM_BYTES - 1;
`endif
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LAST_IDX);
  localparam logic [7:0]       GAP_LAST = 8'(GAP_CYCLES - 1);

  state_t                    state;
  state_t                    state_next;
  logic [BLK_W-1:0]          shreg;
  logic [BLK_W-1:0]          shreg_next;
  logic [UART_DATA_BITS-1:0] cur_byte;
  logic [CNT_W-1:0]          byte_cnt;
  logic [7:0]                gap_cnt;
`ifdef AES_TX_CHECKSUM_EN
  logic [UART_DATA_BITS-1:0] csum;
`endif

  // The outgoing byte always sits at the head of the shift register.
  always_comb begin
    if (MSB_FIRST) begin
      cur_byte   = shreg[BLK_W-1 -: UART_DATA_BITS];
      shreg_next = {shreg[BLK_W-UART_DATA_BITS-1:0], {UART_DATA_BITS{1'b0}}};
    end else begin
      cur_byte   = shreg[UART_DATA_BITS-1:0];
      shreg_next = {{UART_DATA_BITS{1'b0}}, shreg[BLK_W-1:UART_DATA_BITS]};
    end
  end

  always_comb begin
    tx_data = cur_byte;
`ifdef AES_TX_CHECKSUM_EN
    if (byte_cnt == CNT_W'(NUM_BYTES)) tx_data = csum;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else if (en) begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    blk_ready  = 1'b0;
    tx_start   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        blk_ready = en && !rst;
        if (blk_valid && blk_ready) state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        busy       = 1'b1;
        tx_start   = en && !rst;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        busy = 1'b1;
        if (tx_done) begin
          if (byte_cnt == LAST_CNT) state_next = ST_FIN;
          else if (GAP_CYCLES > 0)  state_next = ST_GAP;
          else                      state_next = ST_ISSUE;
        end
      end
      ST_GAP: begin
        busy = 1'b1;
        if (gap_cnt == GAP_LAST) state_next = ST_ISSUE;
      end
      ST_FIN: begin
        done       = en && !rst;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg    <= '0;
      byte_cnt <= '0;
      gap_cnt  <= '0;
`ifdef AES_TX_CHECKSUM_EN
      csum     <= '0;
`endif
    end else if (en) begin
      case (state)
        ST_IDLE: begin
          if (blk_valid && blk_ready) begin
            shreg    <= blk_data;
            byte_cnt <= '0;
            gap_cnt  <= '0;
`ifdef AES_TX_CHECKSUM_EN
            csum     <= '0;
`endif
          end
        end
        ST_WAIT: begin
          if (tx_done) begin
            byte_cnt <= byte_cnt + 1'b1;
            shreg    <= shreg_next;
            gap_cnt  <= '0;
`ifdef AES_TX_CHECKSUM_EN
            // Only data bytes feed the checksum, never the checksum frame itself.
            if (byte_cnt < CNT_W'(NUM_BYTES)) csum <= csum ^ cur_byte;
`endif
          end
        end
        ST_GAP: gap_cnt <= gap_cnt + 1'b1;
        default: ;
      endcase
    end
  end

endmodule
